// File: rtl/irq_dispatch_pkg.sv
// Shared types and constants for the interrupt dispatcher.
package irq_dispatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_REQ,
    ST_CLEAR,
    ST_HOLDOFF
  } state_e;

  localparam logic [1:0] BUS_A = 2'd0;
  localparam logic [1:0] BUS_B = 2'd1;
  localparam logic [1:0] BUS_C = 2'd2;

  localparam logic [3:0] CHAN_MAX = 4'd8;

  typedef logic [5:0] vec_t;

  typedef struct packed {
    logic       ga;
    logic       gb;
    logic       gc;
    logic [3:0] chan;
  } sample_t;

  // Bus A outranks B, which outranks C, when several grant flags are high.
  function automatic vec_t encode_vec(input sample_t s);
    logic [1:0] bus;
    if (s.ga)      bus = BUS_A;
    else if (s.gb) bus = BUS_B;
    else           bus = BUS_C;
    return {bus, s.chan};
  endfunction

endpackage

// File: rtl/irq_stable_filter.sv
// Input register plus run-length stability counter for the encoder sample word.
module irq_stable_filter
  import irq_dispatch_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ga_i,
  input  logic       gb_i,
  input  logic       gc_i,
  input  logic [3:0] chan_i,
  input  logic       load_i,
  input  logic       run_i,
  output logic       any_o,
  output logic       stable_o,
  output sample_t    word_o
);

  localparam logic [3:0] STABLE_W = 4'(STABLE_CYC);

  sample_t    samp_q;
  sample_t    prev_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      samp_q <= {ga_i, gb_i, gc_i, chan_i};
      prev_q <= samp_q;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 4'd1;
    end else if (run_i) begin
      if (samp_q == prev_q) begin
        if (cnt_q != '1) cnt_d = cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
    end
  end

  // Once the count is reached, prev_q holds the last sample that was counted.
  assign stable_o = run_i && (cnt_q == STABLE_W);
  assign word_o   = prev_q;
  assign any_o    = samp_q.ga | samp_q.gb | samp_q.gc;

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: stable-sample capture, CPU req/ack handshake, latch clear.
// Optional serviced-interrupt counter enabled by IRQ_DISPATCH_STATS_EN.
module irq_dispatch
  import irq_dispatch_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = 2,
  parameter int unsigned HOLDOFF_CYC = 3,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ga_i,
  input  logic        gb_i,
  input  logic        gc_i,
  input  logic [3:0]  chan_i,
  output logic        irq_o,
  output logic [5:0]  vec_o,
  input  logic        ack_i,
  output logic        clr_o,
  output logic [5:0]  clr_vec_o,
  output logic        err_o,
  output logic [15:0] svc_cnt_o
);

  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);
  localparam logic [3:0]  HO_LAST = 4'(HOLDOFF_CYC - 1);

  state_e      state_q, state_d;
  logic [15:0] to_q, to_d;
  logic [3:0]  ho_q, ho_d;
  logic        ack_q;
  logic        irq_q, irq_d;
  vec_t        vec_q, vec_d;
  logic        clr_q, clr_d;
  vec_t        clr_vec_q, clr_vec_d;
  logic        err_q, err_d;

  logic        flt_load, flt_run, flt_any, flt_stable;
  sample_t     flt_word;

  irq_stable_filter #(
    .STABLE_CYC(STABLE_CYC)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .ga_i     (ga_i),
    .gb_i     (gb_i),
    .gc_i     (gc_i),
    .chan_i   (chan_i),
    .load_i   (flt_load),
    .run_i    (flt_run),
    .any_o    (flt_any),
    .stable_o (flt_stable),
    .word_o   (flt_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      to_q      <= '0;
      ho_q      <= '0;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
      vec_q     <= '0;
      clr_q     <= 1'b0;
      clr_vec_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      ho_q      <= ho_d;
      // Ack is registered, and only an ack seen while requesting is kept.
      ack_q     <= ack_i && (state_q == ST_REQ);
      irq_q     <= irq_d;
      vec_q     <= vec_d;
      clr_q     <= clr_d;
      clr_vec_q <= clr_vec_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    ho_d      = ho_q;
    irq_d     = irq_q;
    vec_d     = vec_q;
    clr_d     = 1'b0;
    clr_vec_d = clr_vec_q;
    err_d     = 1'b0;
    flt_load  = 1'b0;
    flt_run   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (flt_any) begin
          flt_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        flt_run = 1'b1;
        if (flt_stable) begin
          if (flt_word.chan > CHAN_MAX) begin
            err_d   = 1'b1;
            ho_d    = '0;
            state_d = ST_HOLDOFF;
          end else begin
            vec_d   = encode_vec(flt_word);
            irq_d   = 1'b1;
            to_d    = '0;
            state_d = ST_REQ;
          end
        end else if (!flt_any) begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Ack takes precedence over a timeout expiring on the same edge.
        if (ack_q) begin
          irq_d     = 1'b0;
          clr_d     = 1'b1;
          clr_vec_d = vec_q;
          state_d   = ST_CLEAR;
        end else if (to_q == TO_LAST) begin
          irq_d   = 1'b0;
          err_d   = 1'b1;
          ho_d    = '0;
          state_d = ST_HOLDOFF;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      ST_CLEAR: begin
        ho_d    = '0;
        state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (ho_q == HO_LAST) state_d = ST_IDLE;
        else                 ho_d    = ho_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign irq_o     = irq_q;
  assign vec_o     = vec_q;
  assign clr_o     = clr_q;
  assign clr_vec_o = clr_vec_q;
  assign err_o     = err_q;

`ifdef IRQ_DISPATCH_STATS_EN
  logic [15:0] svc_q, svc_d;
  logic        svc_inc;

  assign svc_inc = (state_q == ST_REQ) && (state_d == ST_CLEAR);

  always_comb begin
    svc_d = svc_q;
    if (svc_inc && (svc_q != '1)) svc_d = svc_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) svc_q <= '0;
    else     svc_q <= svc_d;
  end

  assign svc_cnt_o = svc_q;
`else
  assign svc_cnt_o = '0;
`endif

endmodule

// File: doc/irq_dispatch.md
# irq_dispatch

Synchronous dispatcher downstream of the 27-channel combinational priority interrupt encoder. It samples the encoder's three bus-grant flags and 4-bit channel code and accepts a sample only once it is stable. It then presents a registered 6-bit vector to the CPU with a req/ack handshake, and finally pulses a clear back to the request latches before the next arbitration.

## Interface
Parameters:
- STABLE_CYC, 2, consecutive identical samples required before capture (1..15)
- HOLDOFF_CYC, 3, idle cycles after clear so the encoder re-settles (1..15)
- ACK_TIMEOUT, 255, cycles in REQ before abandoning (1..65535)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- ga_i  in  1  bus A grant flag from encoder, active-high
- gb_i  in  1  bus B grant flag, active-high
- gc_i  in  1  bus C grant flag, active-high
- chan_i  in  4  encoded winning channel within bus, legal 0..8
- irq_o  out  1  interrupt request to CPU
- vec_o  out  6  {bus[1:0], chan[3:0]}; bus A=0, B=1, C=2
- ack_i  in  1  CPU acknowledge
- clr_o  out  1  one-cycle clear strobe to request latches
- clr_vec_o  out  6  vector being cleared, valid with clr_o
- err_o  out  1  one-cycle strobe: illegal channel or ack timeout
- svc_cnt_o  out  16  serviced-interrupt count (see Configuration)

## Operation
- Sample word = {ga_i, gb_i, gc_i, chan_i}, registered every cycle. Bus code comes from fixed priority A>B>C when several flags are high.
- States: IDLE, SETTLE, REQ, CLEAR, HOLDOFF.
- IDLE: any flag high -> SETTLE, with the stability counter loaded to 1.
- SETTLE: a sample equal to the previous one increments the counter; any difference reloads it to 1; all flags low -> IDLE. When the counter reaches STABLE_CYC:
  - chan > 8: pulse err_o, go to HOLDOFF.
  - otherwise latch vec_o and go to REQ.
- REQ: irq_o=1, vec_o held constant.
  - ack_i=1 -> CLEAR.
  - ACK_TIMEOUT cycles without ack -> err_o pulse, go to HOLDOFF; no clear is issued.
- CLEAR: clr_o=1 and clr_vec_o=vec_o for exactly one cycle, then HOLDOFF.
- HOLDOFF: count HOLDOFF_CYC cycles, ignoring inputs, then IDLE.
- ack_i outside REQ is ignored.
- Input changes during REQ do not affect vec_o. Higher-priority arrivals wait for the next pass.

## Timing
- Reset values:
  - state=IDLE.
  - irq_o, clr_o, err_o = 0.
  - vec_o, clr_vec_o = 6'h00.
  - svc_cnt_o = 0; all counters 0.
- Reset asserted in any state returns to IDLE on the next edge. A pending irq_o drops and no clr_o is emitted.
- Minimum latency from a stable input to irq_o rising = 1 (input register) + STABLE_CYC + 1 cycles. For default parameters this is 4 edges.
- An ack_i sampled high on edge k gives irq_o=0 and clr_o=1 after edge k+1. clr_o falls after edge k+2.
- All outputs are registered; there are no combinational paths from input to output.
- Timeout counter width is 16 bits. It starts at 0 on REQ entry, and the timeout fires when it reaches ACK_TIMEOUT-1 with ack_i still low.
- Ack on the same edge as timeout expiry: ack wins and the block goes to CLEAR.

## Configuration
- IRQ_DISPATCH_STATS_EN defined: svc_cnt_o increments once per CLEAR entry and saturates at 16'hFFFF. Reset clears it.
- Not defined: the counter is not built and svc_cnt_o is tied to 16'h0000. All other behaviour is identical.

## Structure
- irq_dispatch_pkg holds:
  - the state enum type;
  - bus-code constants BUS_A=2'd0, BUS_B=2'd1, BUS_C=2'd2;
  - the 6-bit vector typedef;
  - the CHAN_MAX=4'd8 constant.
- One sub-module, irq_stable_filter, contains the input register, previous-sample compare, stability counter and a stable strobe. It is parameterised by STABLE_CYC.
- The FSM, the timeout and holdoff counters, and the stats counter live in irq_dispatch.

## Test plan
- Reset, then gb_i=1, chan_i=5 held -> irq_o=1 and vec_o=6'h15 four cycles later. ack_i one cycle -> clr_o pulse with clr_vec_o=6'h15, then 3 holdoff cycles, then IDLE.
- ga_i=1 and gc_i=1, chan_i=2 -> vec_o=6'h02 (bus A wins).
- chan_i toggling 3/4 every cycle with ga_i=1 -> never leaves SETTLE and irq_o stays 0. Hold chan_i=4 for 2 cycles -> vec_o=6'h04.
- gc_i=1, chan_i=4'hB stable -> err_o single pulse, no irq_o, HOLDOFF entered.
- REQ with no ack for 255 cycles -> err_o pulse, irq_o drops, clr_o never asserts. A repeat run with ack on the expiry cycle -> clr_o asserted.
- rst asserted in REQ -> irq_o=0 next cycle, no clr_o. With IRQ_DISPATCH_STATS_EN, 3 serviced interrupts -> svc_cnt_o=3; without it, svc_cnt_o=0.
